// File: rtl/wb_conmax_pri_arb.sv
// Per-slave-port priority arbiter for the 8-master Wishbone interconnect.
// Highest effective priority wins, round-robin within a level, and a grant
// is held until its master drops its request (no preemption).
module wb_conmax_pri_arb #(
    parameter logic [1:0] PriSel = 2'd2  // 0: one level, 1: two levels, 2: four levels
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] conf_i,
    input  logic [7:0]  req_i,
    output logic [2:0]  gnt_o,
    output logic        gnt_vld_o,
    output logic [7:0]  gnt_oh_o
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          st_q, st_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [3:0][2:0] rr_q, rr_d;     // last master granted at each level

    logic [7:0][1:0] ep;             // effective priority per master
    logic [3:0][7:0] lvl_req;        // requesting masters grouped by level
    logic [1:0]      lvl;            // highest level with a pending request
    logic [2:0]      start;
    logic [2:0]      idx;
    logic            found;
    logic [2:0]      win;
    logic            arb_en;

    // Map the configuration word to an effective priority per master.
    always_comb begin
        for (int m = 0; m < 8; m++) begin
            case (PriSel)
                2'd0:    ep[m] = 2'd0;
                2'd1:    ep[m] = {1'b0, conf_i[2*m+1]};
                default: ep[m] = conf_i[2*m +: 2];
            endcase
        end
    end

    // Split the requests by level and pick the highest populated level.
    always_comb begin
        lvl_req = '0;
        for (int m = 0; m < 8; m++) begin
            lvl_req[ep[m]][m] = req_i[m];
        end
        lvl = 2'd0;
        for (int l = 0; l < 4; l++) begin
            if (|lvl_req[l]) begin
                lvl = 2'(l);
            end
        end
    end

    // Round-robin search within the winning level, starting after its pointer.
    always_comb begin
        start = rr_q[lvl] + 3'd1;
        idx   = start;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && lvl_req[lvl][idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st_q  <= StIdle;
            gnt_q <= 3'd0;
            rr_q  <= {4{3'd7}};
        end else begin
            st_q  <= st_d;
            gnt_q <= gnt_d;
            rr_q  <= rr_d;
        end
    end

    // Next state: arbitrate from idle, or on release of the current owner.
    always_comb begin
        st_d   = st_q;
        gnt_d  = gnt_q;
        rr_d   = rr_q;
        arb_en = (|req_i) && ((st_q == StIdle) || !req_i[gnt_q]);
        if (arb_en) begin
            st_d      = StBusy;
            gnt_d     = win;
            rr_d[lvl] = win;
        end else if (req_i == 8'd0) begin
            st_d = StIdle;
        end
    end

    // Outputs come straight from registers only.
    always_comb begin
        gnt_o     = gnt_q;
        gnt_vld_o = (st_q == StBusy);
        gnt_oh_o  = 8'd0;
        if (st_q == StBusy) begin
            gnt_oh_o[gnt_q] = 1'b1;
        end
    end

endmodule
